// File: rtl/axis_level_fifo_if.sv
// AXI-Stream word channel (tdata/tlast with valid/ready) shared by the FIFO's input and output sides.
// Latency: none, wires only. Backpressure: tready from the sink, tvalid from the source.
interface axis_level_fifo_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_level_fifo.sv
// Stream FIFO with a first-word-fall-through output register, level/frame counters and threshold flags.
// Latency: 1 cycle from an accepted word to m_axis.tvalid; AXIS_LEVEL_FIFO_FRAME_MODE_EN holds output until a whole frame is stored.
// Backpressure: s_axis.tready is registered as (level != DEPTH) and has no combinational path from m_axis.tready.
module axis_level_fifo #(
    parameter int DEPTH         = 512,
    parameter int DATA_WIDTH    = 64,
    parameter int AFULL_THRESH  = DEPTH - 8,
    parameter int AEMPTY_THRESH = 8
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_areset,
    axis_level_fifo_if.slave        s_axis,
    axis_level_fifo_if.master       m_axis,
    output logic [$clog2(DEPTH):0]  status_level,
    output logic [$clog2(DEPTH):0]  status_frames,
    output logic                    status_afull,
    output logic                    status_aempty,
    output logic                    status_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] FULL_LVL   = LW'(DEPTH);
    localparam logic [AW:0] AFULL_LVL  = LW'(AFULL_THRESH);
    localparam logic [AW:0] AEMPTY_LVL = LW'(AEMPTY_THRESH);
    localparam logic [AW:0] ONE        = LW'(1);

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [DATA_WIDTH:0]   mem_rd;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] out_dat;
    logic                  out_last;
    logic                  out_vld;
    logic                  s_rdy;
    logic                  m_vld;
    logic                  push;
    logic                  pop;
    logic                  mem_empty;
    logic                  out_free;
    logic                  load_mem;
    logic                  load_byp;
    logic                  mem_wr;
    logic [AW:0]           level_nxt;
    logic [AW:0]           frames_nxt;

    assign push      = s_axis.tvalid && s_rdy;
    assign pop       = m_vld && m_axis.tready;
    assign mem_empty = (wr_ptr == rd_ptr);
    assign out_free  = !out_vld || pop;
    // Memory head always has priority for the output register; the bypass only
    // serves a push arriving while nothing older is waiting.
    assign load_mem  = out_free && !mem_empty;
    assign load_byp  = out_free && mem_empty && push;
    assign mem_wr    = push && !load_byp;
    assign mem_rd    = mem[rd_ptr[AW-1:0]];

`ifdef AXIS_LEVEL_FIFO_FRAME_MODE_EN
    logic release_q;

    // A full FIFO without a complete frame would never drain; cut through until a tlast leaves.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            release_q <= 1'b0;
        end else if (pop && out_last) begin
            release_q <= 1'b0;
        end else if (status_level == FULL_LVL && status_frames == '0) begin
            release_q <= 1'b1;
        end
    end

    assign m_vld = out_vld && (status_frames != '0 || release_q || status_level == FULL_LVL);
`else
    assign m_vld = out_vld;
`endif

    always_comb begin
        level_nxt = status_level;
        case ({push, pop})
            2'b10:   level_nxt = status_level + ONE;
            2'b01:   level_nxt = status_level - ONE;
            default: level_nxt = status_level;
        endcase
    end

    always_comb begin
        frames_nxt = status_frames;
        case ({push && s_axis.tlast, pop && out_last})
            2'b10:   frames_nxt = status_frames + ONE;
            2'b01:   frames_nxt = status_frames - ONE;
            default: frames_nxt = status_frames;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (mem_wr) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            out_dat         <= '0;
            out_last        <= 1'b0;
            out_vld         <= 1'b0;
            s_rdy           <= 1'b0;
            status_level    <= '0;
            status_frames   <= '0;
            status_afull    <= 1'b0;
            status_aempty   <= 1'b1;
            status_overflow <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (load_mem) begin
                rd_ptr   <= rd_ptr + ONE;
                out_dat  <= mem_rd[DATA_WIDTH-1:0];
                out_last <= mem_rd[DATA_WIDTH];
                out_vld  <= 1'b1;
            end else if (load_byp) begin
                out_dat  <= s_axis.tdata;
                out_last <= s_axis.tlast;
                out_vld  <= 1'b1;
            end else if (out_free) begin
                out_vld  <= 1'b0;
            end
            s_rdy         <= (level_nxt != FULL_LVL);
            status_level  <= level_nxt;
            status_frames <= frames_nxt;
            // Flags follow the registered level, so they trail it by one cycle.
            status_afull  <= (status_level >= AFULL_LVL);
            status_aempty <= (status_level <= AEMPTY_LVL);
            if (s_axis.tvalid && status_level == FULL_LVL) begin
                status_overflow <= 1'b1;
            end
        end
    end

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = m_vld;
    assign m_axis.tdata  = out_dat;
    assign m_axis.tlast  = out_last;
endmodule

// File: tb/tb_axis_level_fifo.sv
// Scoreboard bench for axis_level_fifo at DEPTH=16; define AXIS_LEVEL_FIFO_FRAME_MODE_EN to exercise store-and-forward.
// Stimulus queues expected words, a negedge monitor pops and compares them and tracks level/frames every cycle.
module tb_axis_level_fifo;
    logic       clk;
    logic       rst;
    logic [4:0] level;
    logic [4:0] frames;
    logic       afull;
    logic       aempty;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int mdl_cnt = 0;
    int mdl_frm = 0;
    bit rnd_done;
    logic [64:0] exp_q [$];

    axis_level_fifo_if #(.DATA_WIDTH(64)) s_if ();
    axis_level_fifo_if #(.DATA_WIDTH(64)) m_if ();

    axis_level_fifo #(
        .DEPTH(16), .DATA_WIDTH(64), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
    ) dut (
        .s_axis_aclk     (clk),
        .s_axis_areset   (rst),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .status_level    (level),
        .status_frames   (frames),
        .status_afull    (afull),
        .status_aempty   (aempty),
        .status_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_if.tready) begin
                exp_q.push_back({l, d});
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        s_if.tvalid = 1'b0;
        if (!ok) fail("push_timeout");
    endtask

    task automatic drain();
        m_if.tready = 1'b1;
        for (int n = 0; n < 500; n++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        step();
        step();
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check("drain_level", 64'(level), 64'd0);
    endtask

    // Monitor: level/frames against a handshake-count model, output words against the queue.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mdl_cnt = 0;
                mdl_frm = 0;
            end else begin
                check("level", 64'(level), 64'(mdl_cnt));
                check("frames", 64'(frames), 64'(mdl_frm));
                if (s_if.tvalid && s_if.tready) begin
                    mdl_cnt++;
                    if (s_if.tlast) mdl_frm++;
                end
                if (m_if.tvalid && m_if.tready) begin
                    mdl_cnt--;
                    if (m_if.tlast) mdl_frm--;
                    if (exp_q.size() == 0) begin
                        fail("unexpected_pop");
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", m_if.tdata, e[63:0]);
                        check("tlast", 64'(m_if.tlast), 64'(e[64]));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        #3;
        check("rst_tready", 64'(s_if.tready), 64'd0);
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_tdata", m_if.tdata, 64'd0);
        check("rst_tlast", 64'(m_if.tlast), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_frames", 64'(frames), 64'd0);
        check("rst_afull", 64'(afull), 64'd0);
        check("rst_aempty", 64'(aempty), 64'd1);
        check("rst_overflow", 64'(overflow), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rdy_before_edge", 64'(s_if.tready), 64'd0);
        step();
        check("rdy_after_edge", 64'(s_if.tready), 64'd1);

        // Single word fall-through
        check("idle_tvalid", 64'(m_if.tvalid), 64'd0);
        push_word(64'hA5, 1'b1);
        check("fwft_tvalid", 64'(m_if.tvalid), 64'd1);
        check("fwft_tdata", m_if.tdata, 64'hA5);
        m_if.tready = 1'b1;
        step();
        check("single_level", 64'(level), 64'd0);
        check("single_tvalid", 64'(m_if.tvalid), 64'd0);

        // Fill to capacity, then hold tvalid against a full FIFO
        m_if.tready = 1'b0;
        for (int i = 0; i < 16; i++) push_word(64'h100 + 64'(i), 1'b0);
        check("full_tready", 64'(s_if.tready), 64'd0);
        check("full_level", 64'(level), 64'd16);
        check("full_afull", 64'(afull), 64'd1);
        check("full_aempty", 64'(aempty), 64'd0);
        s_if.tdata  = 64'hDEAD;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        repeat (3) step();
        s_if.tvalid = 1'b0;
        check("overflow", 64'(overflow), 64'd1);
        check("ovf_level", 64'(level), 64'd16);
        check("ovf_head", m_if.tdata, 64'h100);

        // Pop from full, then stream across the pointer wrap
        m_if.tready = 1'b1;
        step();
        check("rdy_after_pop", 64'(s_if.tready), 64'd1);
        for (int i = 0; i < 40; i++) push_word(64'h200 + 64'(i), (i == 39));
        drain();
        check("overflow_sticky", 64'(overflow), 64'd1);
        check("empty_aempty", 64'(aempty), 64'd1);

        // Random valid/ready traffic
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 1) == 1) step();
                    push_word({$urandom, $urandom}, (i % 5 == 4) || (i == 999));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    m_if.tready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        drain();

        // Five-word frame, tlast on the fifth
        rst = 1'b1;
        exp_q.delete();
        m_if.tready = 1'b0;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            push_word(64'h300 + 64'(i), 1'b0);
            check("frm_pre_frames", 64'(frames), 64'd0);
`ifdef AXIS_LEVEL_FIFO_FRAME_MODE_EN
            check("frm_pre_tvalid", 64'(m_if.tvalid), 64'd0);
`else
            check("frm_pre_tvalid", 64'(m_if.tvalid), 64'd1);
`endif
        end
        push_word(64'h304, 1'b1);
        check("frm_post_frames", 64'(frames), 64'd1);
        check("frm_post_tvalid", 64'(m_if.tvalid), 64'd1);
        drain();
        check("frm_done_frames", 64'(frames), 64'd0);

        // Reset in the middle of a frame with seven words held
        m_if.tready = 1'b0;
        for (int i = 0; i < 7; i++) push_word(64'h400 + 64'(i), (i == 2));
        check("mid_level", 64'(level), 64'd7);
        check("mid_tvalid", 64'(m_if.tvalid), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_tvalid", 64'(m_if.tvalid), 64'd0);
        check("async_level", 64'(level), 64'd0);
        check("async_tready", 64'(s_if.tready), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_rst_level", 64'(level), 64'd0);
        check("post_rst_frames", 64'(frames), 64'd0);
        check("post_rst_tready", 64'(s_if.tready), 64'd1);
        m_if.tready = 1'b1;
        push_word(64'h77, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_level_fifo.md
AXIS_LEVEL_FIFO -- requirements
Module: axis_level_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning word capacity; it must be a power of two and at least 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning tdata width in bits.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-8, meaning the level at or above which almost-full asserts.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 8, meaning the level at or below which almost-empty asserts.
REQ-005 SHALL have port s_axis_aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port s_axis_areset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have the slave stream ports: s_axis_tdata (input, DATA_WIDTH); s_axis_tlast (input, 1); s_axis_tvalid (input, 1); s_axis_tready (output, 1).
REQ-008 SHALL have the master stream ports: m_axis_tdata (output, DATA_WIDTH); m_axis_tlast (output, 1); m_axis_tvalid (output, 1); m_axis_tready (input, 1).
REQ-009 SHALL have port status_level, output, $clog2(DEPTH)+1 bits: words held, including the output register.
REQ-010 SHALL have port status_frames, output, $clog2(DEPTH)+1 bits: complete frames held (tlast words not yet popped).
REQ-011 SHALL have ports status_afull and status_aempty, outputs, 1 bit each: registered threshold flags.
REQ-012 SHALL have port status_overflow, output, 1 bit: sticky flag, set when s_axis_tvalid is high while the FIFO is full.

Function
REQ-013 SHALL push a word (tdata plus tlast) on a cycle with s_axis_tvalid && s_axis_tready, and pop on a cycle with m_axis_tvalid && m_axis_tready.
REQ-014 SHALL drive s_axis_tready = (status_level != DEPTH), registered, with no combinational path from m_axis_tready.
REQ-015 SHALL store words in a DEPTH-entry memory with wrapping read/write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
REQ-016 SHALL present data first-word-fall-through through one output register: a push into an empty FIFO raises m_axis_tvalid on the next clock edge (1-cycle latency).
REQ-017 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tvalid stable while m_axis_tvalid && !m_axis_tready.
REQ-018 SHALL sustain one push and one pop per cycle; simultaneous push and pop leaves status_level unchanged.
REQ-019 SHALL, on a pop that empties the FIFO, deassert m_axis_tvalid on the same edge unless a push occurs on that cycle.
REQ-020 SHALL, when full, raise s_axis_tready on the edge following a pop; a push in the full-and-pop cycle is not accepted.
REQ-021 SHALL update status_frames as +1 on a push with tlast and -1 on a pop with tlast; the two cancel when both occur in one cycle.
REQ-022 SHALL register status_afull = (level >= AFULL_THRESH) and status_aempty = (level <= AEMPTY_THRESH), each updated one cycle after the level changes.
REQ-023 SHALL make status_overflow sticky; it is cleared only by reset, and no data is written while the FIFO is full.

Reset
REQ-024 SHALL, while s_axis_areset is high, asynchronously force: pointers = 0; status_level = 0; status_frames = 0; m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tdata = 0; s_axis_tready = 0; status_afull = 0; status_aempty = 1; status_overflow = 0.
REQ-025 SHALL raise s_axis_tready on the first rising edge after reset deasserts.
REQ-026 SHALL discard all stored words when reset is asserted mid-frame or mid-transfer; memory contents need not be cleared.

Configuration
REQ-027 SHALL, when macro AXIS_LEVEL_FIFO_FRAME_MODE_EN is defined, operate store-and-forward: m_axis_tvalid asserts only while status_frames > 0, or while the FIFO is full with status_frames == 0 (deadlock release, cut-through until the next tlast pops).
REQ-028 SHALL, without AXIS_LEVEL_FIFO_FRAME_MODE_EN, operate cut-through per REQ-016; status_frames remains functional in both modes.

Verification (DEPTH=16, DATA_WIDTH=64, AFULL_THRESH=12, AEMPTY_THRESH=2)
REQ-029 SHALL cover reset then a single push of 0xA5 with m_axis_tready=1 -> m_axis_tvalid high exactly 1 cycle after the push, tdata=0xA5, then status_level returns to 0.
REQ-030 SHALL cover 16 pushes with m_axis_tready=0 -> s_axis_tready low after the 16th push, status_level=16, status_afull=1; a 17th tvalid held high -> status_overflow=1 and data is unchanged.
REQ-031 SHALL cover a full FIFO with continuous push and pop -> 1 pop, s_axis_tready high next cycle; output order 0..N is preserved across pointer wrap for 40 words.
REQ-032 SHALL cover random tvalid/tready at 50% for 1000 words -> output matches the input sequence, and status_level equals the model count every cycle.
REQ-033 SHALL cover frame mode with 5 words pushed and tlast on word 5 -> m_axis_tvalid stays low until the tlast push, then high; status_frames goes 0->1->0.
REQ-034 SHALL cover reset asserted with level=7 mid-frame -> m_axis_tvalid=0 immediately (asynchronous), and level=0, frames=0 after release.
